// File: rtl/ifu_prefetch.sv
`default_nettype none
// ============================================================================
// Module      : ifu_prefetch
// Description : Instruction fetch unit with pipelined bus requests and an
//               in-order prefetch FIFO feeding the IF/ID register.
// Revision    : 1.0 - initial release
// ============================================================================
module ifu_prefetch #(
    parameter int          DEPTH    = 4,
    parameter int          MAX_OUT  = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_flag_i,
    input  logic [31:0] jump_addr_i,
    input  logic [2:0]  hold_flag_i,
    input  logic        stall_flag_i,
    output logic        ibus_req_o,
    output logic [31:0] ibus_addr_o,
    input  logic        ibus_gnt_i,
    input  logic        ibus_rvalid_i,
    input  logic [31:0] ibus_rdata_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o
);

    localparam int               c_AW       = $clog2(DEPTH);
    localparam int               c_CW       = $clog2(DEPTH + 1);
    localparam int               c_OW       = $clog2(MAX_OUT + 1);
    localparam logic [2:0]       c_HOLD_PC  = 3'd1;
    localparam logic [2:0]       c_HOLD_IF  = 3'd2;
    localparam logic [31:0]      c_INST_NOP = 32'h0000_0013;
    localparam logic [c_AW-1:0]  c_PTR_ONE  = c_AW'(1);
    localparam logic [c_CW-1:0]  c_CNT_ONE  = c_CW'(1);
    localparam logic [c_OW-1:0]  c_OUT_ONE  = c_OW'(1);

    logic [31:0]     r_pc;
    logic [c_OW-1:0] r_out;
    logic [c_OW-1:0] r_drop;
    logic [c_CW-1:0] r_count;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_AW-1:0] r_wr_ptr;
    logic [31:0]     r_data_mem [DEPTH];
    logic [31:0]     r_addr_mem [DEPTH];

    logic            w_gnt;
    logic            w_rv;
    logic            w_push;
    logic            w_pop;
    logic [c_OW-1:0] w_out_next;
    logic [c_OW-1:0] w_live;
    logic [31:0]     w_resp_addr;

    // A response with no request in flight (e.g. leftover from before reset) is ignored.
    assign w_rv   = ibus_rvalid_i && (r_out != '0);
    assign w_gnt  = ibus_req_o && ibus_gnt_i;
    assign w_push = w_rv && (r_drop == '0) && !jump_flag_i;
    assign w_pop  = (r_count != '0) && !stall_flag_i && (hold_flag_i < c_HOLD_IF);

    // Live (non-dropped) requests were granted contiguously ending at pc-4,
    // so the oldest one's address follows directly from the pc.
    assign w_live      = r_out - r_drop;
    assign w_resp_addr = r_pc - (32'(w_live) << 2);

    assign ibus_req_o  = rst && !jump_flag_i && (hold_flag_i < c_HOLD_PC) &&
                         (32'(r_out) < 32'(MAX_OUT)) &&
                         ((32'(r_count) + 32'(r_out)) < 32'(DEPTH));
    assign ibus_addr_o = r_pc;

    assign inst_o      = (r_count == '0) ? c_INST_NOP : r_data_mem[r_rd_ptr];
    assign inst_addr_o = (r_count == '0) ? 32'h0 : r_addr_mem[r_rd_ptr];

    always_comb begin
        w_out_next = r_out;
        if (w_gnt && !w_rv) begin
            w_out_next = r_out + c_OUT_ONE;
        end else if (!w_gnt && w_rv) begin
            w_out_next = r_out - c_OUT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pc     <= RESET_PC;
            r_out    <= '0;
            r_drop   <= '0;
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else begin
            r_out <= w_out_next;
            if (jump_flag_i) begin
                // Everything still in flight belongs to the abandoned path.
                r_pc     <= jump_addr_i;
                r_drop   <= w_out_next;
                r_count  <= '0;
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
            end else begin
                if (w_gnt) begin
                    r_pc <= r_pc + 32'd4;
                end
                if (w_rv && (r_drop != '0)) begin
                    r_drop <= r_drop - c_OUT_ONE;
                end
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
                end
                if (w_push && !w_pop) begin
                    r_count <= r_count + c_CNT_ONE;
                end else if (!w_push && w_pop) begin
                    r_count <= r_count - c_CNT_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_data_mem[r_wr_ptr] <= ibus_rdata_i;
            r_addr_mem[r_wr_ptr] <= w_resp_addr;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ifu_prefetch.sv
`default_nettype none
// Testbench for ifu_prefetch: random bus/pipeline stimulus against a queue-based
// reference model of the fetch path.
`timescale 1ns/1ps
module tb_ifu_prefetch;

    localparam int          DEPTH    = 4;
    localparam int          MAX_OUT  = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          NPH      = 5;
    localparam int PH_CYC  [NPH] = '{40, 30, 400, 300, 2500};
    localparam int PH_GNT  [NPH] = '{100, 100, 70, 80, 60};
    localparam int PH_RV   [NPH] = '{100, 100, 60, 70, 50};
    localparam int PH_STL  [NPH] = '{0, 80, 20, 10, 25};
    localparam int PH_HOLD [NPH] = '{0, 0, 10, 50, 20};
    localparam int PH_JMP  [NPH] = '{0, 0, 8, 5, 6};
    localparam int PH_RST  [NPH] = '{0, 0, 0, 0, 2};

    logic        clk = 1'b0;
    logic        rst;
    logic        jump_flag;
    logic [31:0] jump_addr;
    logic [2:0]  hold_flag;
    logic        stall_flag;
    logic        ibus_req;
    logic [31:0] ibus_addr;
    logic        ibus_gnt;
    logic        ibus_rvalid;
    logic [31:0] ibus_rdata;
    logic [31:0] inst;
    logic [31:0] inst_addr;

    always #5 clk = ~clk;

    ifu_prefetch #(.DEPTH(DEPTH), .MAX_OUT(MAX_OUT), .RESET_PC(RESET_PC)) dut (
        .clk           (clk),
        .rst           (rst),
        .jump_flag_i   (jump_flag),
        .jump_addr_i   (jump_addr),
        .hold_flag_i   (hold_flag),
        .stall_flag_i  (stall_flag),
        .ibus_req_o    (ibus_req),
        .ibus_addr_o   (ibus_addr),
        .ibus_gnt_i    (ibus_gnt),
        .ibus_rvalid_i (ibus_rvalid),
        .ibus_rdata_i  (ibus_rdata),
        .inst_o        (inst),
        .inst_addr_o   (inst_addr)
    );

    typedef struct {
        logic [31:0] addr;
        bit          stale;
    } flight_t;

    flight_t     m_flight[$];   // requests granted, response not yet seen
    logic [31:0] m_fifo[$];     // addresses of buffered words, oldest first
    logic [31:0] m_pc;
    logic [31:0] bus_q[$];      // addresses the bus still owes a response for
    int          n_vec = 0;
    int          n_bad = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A3C_96E1;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_flight.delete();
        m_fifo.delete();
        bus_q.delete();
        m_pc = RESET_PC;
    endtask

    function automatic bit exp_req();
        return rst && !jump_flag && (hold_flag < 3'd1) &&
               (m_flight.size() < MAX_OUT) &&
               (m_fifo.size() + m_flight.size() < DEPTH);
    endfunction

    task automatic check_outputs();
        bit er;
        er = exp_req();
        check_val("ibus_req", {31'b0, ibus_req}, {31'b0, er});
        if (er) check_val("ibus_addr", ibus_addr, m_pc);
        if (m_fifo.size() > 0) begin
            check_val("inst", inst, mem_word(m_fifo[0]));
            check_val("inst_addr", inst_addr, m_fifo[0]);
        end else begin
            check_val("inst_nop", inst, 32'h0000_0013);
            check_val("inst_addr_zero", inst_addr, 32'h0);
        end
    endtask

    task automatic model_step(input bit er);
        bit      rv_eff;
        bit      pop;
        flight_t f;
        if (!rst) begin
            model_reset();
            return;
        end
        if (ibus_rvalid && bus_q.size() > 0) void'(bus_q.pop_front());
        if (er && ibus_gnt) bus_q.push_back(m_pc);
        rv_eff = ibus_rvalid && (m_flight.size() > 0);
        if (jump_flag) begin
            if (rv_eff) void'(m_flight.pop_front());
            foreach (m_flight[i]) m_flight[i].stale = 1'b1;
            m_fifo.delete();
            m_pc = jump_addr;
        end else begin
            pop = (m_fifo.size() > 0) && !stall_flag && (hold_flag < 3'd2);
            if (pop) void'(m_fifo.pop_front());
            if (rv_eff) begin
                f = m_flight.pop_front();
                if (!f.stale) m_fifo.push_back(f.addr);
            end
            if (er && ibus_gnt) begin
                m_flight.push_back('{addr: m_pc, stale: 1'b0});
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    task automatic drive_random(input int p);
        int r;
        rst        = !($urandom_range(99) < PH_RST[p]);
        stall_flag = ($urandom_range(99) < PH_STL[p]);
        hold_flag  = ($urandom_range(99) < PH_HOLD[p]) ? 3'($urandom_range(1, 7)) : 3'd0;
        ibus_gnt   = ($urandom_range(99) < PH_GNT[p]);
        jump_flag  = ($urandom_range(99) < PH_JMP[p]);
        r = $urandom_range(3);
        case (r)
            0:       jump_addr = 32'h0000_0100;
            1:       jump_addr = 32'hFFFF_FFF8 + 32'($urandom_range(1)) * 32'd4;
            default: jump_addr = $urandom() & 32'hFFFF_FFFC;
        endcase
        ibus_rdata = $urandom();
        if (bus_q.size() > 0 && $urandom_range(99) < PH_RV[p]) begin
            ibus_rvalid = 1'b1;
            ibus_rdata  = mem_word(bus_q[0]);
        end else if (bus_q.size() == 0 && m_flight.size() == 0 && $urandom_range(99) < 8) begin
            ibus_rvalid = 1'b1;  // stray response with nothing in flight
        end else begin
            ibus_rvalid = 1'b0;
        end
    endtask

    task automatic run_cycle(input int p);
        bit er;
        @(negedge clk);
        drive_random(p);
        #1;
        check_outputs();
        er = exp_req();
        @(posedge clk);
        model_step(er);
    endtask

    initial begin
        rst         = 1'b0;
        jump_flag   = 1'b0;
        jump_addr   = 32'h0;
        hold_flag   = 3'd0;
        stall_flag  = 1'b0;
        ibus_gnt    = 1'b0;
        ibus_rvalid = 1'b0;
        ibus_rdata  = 32'h0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_outputs();
        for (int p = 0; p < NPH; p++) begin
            for (int c = 0; c < PH_CYC[p]; c++) begin
                run_cycle(p);
            end
        end
        // Directed wrap: jump to the last word, let it be granted, then check the next address.
        @(negedge clk);
        rst = 1'b1; jump_flag = 1'b1; jump_addr = 32'hFFFF_FFFC;
        hold_flag = 3'd0; stall_flag = 1'b0; ibus_gnt = 1'b0; ibus_rvalid = 1'b0;
        #1;
        check_outputs();
        @(posedge clk);
        model_step(exp_req());
        for (int c = 0; c < 12; c++) run_cycle(0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
